// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: widths, register count and architectural register names.
package mips_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
   localparam logic [ADDR_W-1:0] REG_AT   = 5'd1;
   localparam logic [ADDR_W-1:0] REG_V0   = 5'd2;
   localparam logic [ADDR_W-1:0] REG_V1   = 5'd3;
   localparam logic [ADDR_W-1:0] REG_A0   = 5'd4;
   localparam logic [ADDR_W-1:0] REG_T0   = 5'd8;
   localparam logic [ADDR_W-1:0] REG_S0   = 5'd16;
   localparam logic [ADDR_W-1:0] REG_GP   = 5'd28;
   localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
   localparam logic [ADDR_W-1:0] REG_FP   = 5'd30;
   localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

   // A checked write is dropped when the ALU flags signed overflow.
   function automatic logic ovf_suppress(input logic en, input logic chk, input logic ovf);
      return en & chk & ovf;
   endfunction

endpackage

// File: rtl/alu_regfile_chk.sv
// Property checker for alu_regfile status outputs and the hardwired zero register.
module alu_regfile_chk
   import mips_pkg::*;
(
   input logic              clk,
   input logic              rst_n,
   input logic [ADDR_W-1:0] ra_addr,
   input logic [ADDR_W-1:0] rb_addr,
   input logic [DATA_W-1:0] a_data,
   input logic [DATA_W-1:0] b_data,
   input logic              ovf_trap,
   input logic              ovf_sticky
);

   // A trap pulse is always accompanied by the sticky status.
   a_trap_sticky: assert property (@(posedge clk) disable iff (!rst_n) ovf_trap |-> ovf_sticky);

   // $0 reads as zero on both ports.
   a_zero_a: assert property (@(posedge clk) disable iff (!rst_n)
                              (ra_addr == ZERO_REG) |-> (a_data == {DATA_W{1'b0}}));
   a_zero_b: assert property (@(posedge clk) disable iff (!rst_n)
                              (rb_addr == ZERO_REG) |-> (b_data == {DATA_W{1'b0}}));

endmodule

// File: rtl/rf_read_port.sv
// One combinational register-file read port with $0 forcing and write-through bypass.
module rf_read_port
   import mips_pkg::*;
(
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] regs [NUM_REGS],
   input  logic              byp_en,
   input  logic [ADDR_W-1:0] byp_addr,
   input  logic [DATA_W-1:0] byp_data,
   output logic [DATA_W-1:0] data
);

   // Select zero, the in-flight write, or stored contents.
   always_comb begin
      data = {DATA_W{1'b0}};
      if (addr == ZERO_REG) begin
         data = {DATA_W{1'b0}};
      end else if (byp_en && (byp_addr == addr)) begin
         data = byp_data;
      end else begin
         data = regs[addr];
      end
   end

endmodule

// File: rtl/alu_regfile.sv
// MIPS 32x32 register file feeding the ALU, with overflow-checked write-back,
// registered zero flag and sticky overflow / one-cycle trap status.
module alu_regfile
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] a_data,
   output logic [DATA_W-1:0] b_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_ovf_chk,
   input  logic              alu_ovf,
   input  logic              alu_zero,
   input  logic              flag_we,
   input  logic              ovf_clr,
   output logic              zero_flag,
   output logic              ovf_trap,
   output logic              ovf_sticky,
   output logic [ADDR_W-1:0] trap_reg
);

   logic [DATA_W-1:0] regs_r [NUM_REGS];
   logic              suppress_s;
   logic              wr_eff_s;
   logic              zero_flag_r;
   logic              ovf_trap_r;
   logic              ovf_sticky_r;
   logic [ADDR_W-1:0] trap_reg_r;

   // Suppression ignores the destination so even a trapped $0 write is reported.
   always_comb begin
      suppress_s = ovf_suppress(wr_en, wr_ovf_chk, alu_ovf);
      wr_eff_s   = wr_en & (wr_addr != ZERO_REG) & ~suppress_s;
   end

   // Register storage; entry 0 is never written so it stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_eff_s) begin
         regs_r[wr_addr] <= wr_data;
      end
   end

   // Zero flag, trap pulse, trap address and sticky overflow status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_flag_r  <= 1'b0;
         ovf_trap_r   <= 1'b0;
         ovf_sticky_r <= 1'b0;
         trap_reg_r   <= ZERO_REG;
      end else begin
         ovf_trap_r <= suppress_s;
         if (flag_we) begin
            zero_flag_r <= alu_zero;
         end
         if (suppress_s) begin
            trap_reg_r <= wr_addr;
         end
         // A new suppression outranks a simultaneous clear.
         if (suppress_s) begin
            ovf_sticky_r <= 1'b1;
         end else if (ovf_clr) begin
            ovf_sticky_r <= 1'b0;
         end
      end
   end

   assign zero_flag  = zero_flag_r;
   assign ovf_trap   = ovf_trap_r;
   assign ovf_sticky = ovf_sticky_r;
   assign trap_reg   = trap_reg_r;

   rf_read_port u_port_a (
      .addr     (ra_addr),
      .regs     (regs_r),
      .byp_en   (wr_eff_s),
      .byp_addr (wr_addr),
      .byp_data (wr_data),
      .data     (a_data)
   );

   rf_read_port u_port_b (
      .addr     (rb_addr),
      .regs     (regs_r),
      .byp_en   (wr_eff_s),
      .byp_addr (wr_addr),
      .byp_data (wr_data),
      .data     (b_data)
   );

   alu_regfile_chk u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .ra_addr    (ra_addr),
      .rb_addr    (rb_addr),
      .a_data     (a_data),
      .b_data     (b_data),
      .ovf_trap   (ovf_trap),
      .ovf_sticky (ovf_sticky)
   );

endmodule
